// File: rtl/fadd_seq_ctrl.sv
// fadd_seq_ctrl: multi-cycle FP32 add sequencer around mant_preparer.
// Ports: op_1/op_2 in and res out over valid/ready, prep_* to/from preparer.
module fadd_seq_ctrl #(
  parameter int unsigned BYPASS_DEL = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_1,
  input  logic [31:0] op_2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        busy,
  output logic        prep_sign_op_1,
  output logic        prep_sign_op_2,
  output logic        prep_exp_gr_1,
  output logic        prep_exp_gr_2,
  output logic        prep_exp_eq,
  output logic [7:0]  prep_exp_del,
  output logic [22:0] prep_op_1_f,
  output logic [22:0] prep_op_2_f,
  output logic        prep_denorm_op_1,
  output logic        prep_denorm_op_2,
  input  logic [48:0] prep_op_1_f_pr,
  input  logic [48:0] prep_op_2_f_pr
);

  typedef enum logic [2:0] {
    IDLE, PREP, SUM, NORM, DONE
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [7:0]  BYP  = 8'(BYPASS_DEL);

  function automatic logic [7:0] eff(
    input logic [7:0] e
  );
    return (e == 8'd0) ? 8'd1 : e;
  endfunction

  state_t state, state_d;

  logic [31:0] op_a_q, op_b_q, res_q;
  logic [48:0] a_q, b_q;
  logic [49:0] m_q;
  logic [9:0]  exp_q;
  logic        sign_q;

  // Input-side decode, used only in IDLE
  logic [7:0]  ie_1, ie_2, in_del;
  logic        nan_1, nan_2, inf_1, inf_2;
  logic        spec_hit;
  logic [31:0] spec_res;

  assign ie_1   = eff(op_1[30:23]);
  assign ie_2   = eff(op_2[30:23]);
  assign in_del = (ie_1 >= ie_2) ? ie_1 - ie_2
                                 : ie_2 - ie_1;
  assign nan_1  = (&op_1[30:23]) & (|op_1[22:0]);
  assign nan_2  = (&op_2[30:23]) & (|op_2[22:0]);
  assign inf_1  = (&op_1[30:23]) & ~(|op_1[22:0]);
  assign inf_2  = (&op_2[30:23]) & ~(|op_2[22:0]);

  always_comb begin
    spec_hit = 1'b1;
    spec_res = 32'd0;
    if (nan_1 || nan_2)
      spec_res = QNAN;
    else if (inf_1 && inf_2 && (op_1[31] != op_2[31]))
      spec_res = QNAN;
    else if (inf_1)
      spec_res = op_1;
    else if (inf_2)
      spec_res = op_2;
    else if (in_del >= BYP)
      spec_res = (ie_1 > ie_2) ? op_1 : op_2;
    else
      spec_hit = 1'b0;
  end

  // Preparer drive, from registered operands only
  logic [7:0] re_1, re_2, emin;

  assign re_1 = eff(op_a_q[30:23]);
  assign re_2 = eff(op_b_q[30:23]);
  assign emin = (re_1 < re_2) ? re_1 : re_2;
  assign busy = (state != IDLE);

  assign prep_sign_op_1   = busy & op_a_q[31];
  assign prep_sign_op_2   = busy & op_b_q[31];
  assign prep_exp_gr_1    = busy & (re_1 > re_2);
  assign prep_exp_gr_2    = busy & (re_2 > re_1);
  assign prep_exp_eq      = busy & (re_1 == re_2);
  assign prep_exp_del     = !busy ? 8'd0 :
                            (re_1 >= re_2) ? re_1 - re_2
                                           : re_2 - re_1;
  assign prep_op_1_f      = busy ? op_a_q[22:0] : 23'd0;
  assign prep_op_2_f      = busy ? op_b_q[22:0] : 23'd0;
  assign prep_denorm_op_1 = busy & (op_a_q[30:23] == 8'd0);
  assign prep_denorm_op_2 = busy & (op_b_q[30:23] == 8'd0);

  // Sum and normalise
  logic [49:0] s_sum, s_abs;
  logic [31:0] zero_res, pack;
  logic        shr, shl;

  assign s_sum    = {a_q[48], a_q} + {b_q[48], b_q};
  assign s_abs    = s_sum[49] ? (~s_sum + 50'd1) : s_sum;
  assign zero_res = {op_a_q[31] & op_b_q[31], 31'd0};
  assign shr      = |m_q[49:24];
  assign shl      = ~shr & ~m_q[23] & (exp_q > 10'd1);

  always_comb begin
    pack = {sign_q, exp_q[7:0], m_q[22:0]};
    if (exp_q >= 10'd255)
      pack = {sign_q, 8'hFF, 23'd0};
    else if (!m_q[23])
      pack = {sign_q, 8'h00, m_q[22:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (in_valid)
              state_d = spec_hit ? DONE : PREP;
      PREP: state_d = SUM;
      SUM:  state_d = (s_abs == 50'd0) ? DONE : NORM;
      NORM: if (!shr && !shl) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
      res_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op_a_q <= op_1;
          op_b_q <= op_2;
          if (spec_hit) res_q <= spec_res;
        end
        PREP: begin
          a_q <= prep_op_1_f_pr;
          b_q <= prep_op_2_f_pr;
        end
        SUM: begin
          m_q    <= s_abs;
          exp_q  <= {2'b00, emin};
          sign_q <= s_sum[49];
          if (s_abs == 50'd0) res_q <= zero_res;
        end
        NORM: begin
          unique case (1'b1)
            shr: begin
              m_q   <= m_q >> 1;
              exp_q <= exp_q + 10'd1;
            end
            shl: begin
              m_q   <= m_q << 1;
              exp_q <= exp_q - 10'd1;
            end
            default: res_q <= pack;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign res       = res_q;

endmodule
